if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
- Sequences the instruction-fetch datapath: owns the PC register, drives the instruction-memory read handshake, and presents fetched instructions to the IF/ID boundary.
- Handles decode back-pressure (stall), branch/jump redirect with flush, and memory-timeout error detection.
- Sits between the instruction memory and the IF/ID pipeline register. Replaces a free-running PC incrementer.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 15, maximum consecutive wait cycles (imem_read=1, imem_ready=0) before error; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- stall_in  in  1  decode cannot accept; hold the current IF/ID contents.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  redirect target.
- imem_ready  in  1  instruction memory has valid data for imem_addr this cycle.
- imem_rdata  in  32  instruction memory read data.
- imem_read  out  1  read request; combinational from state and inputs.
- imem_addr  out  32  equals the PC register.
- ifid_valid  out  1  ifid_instr/ifid_pc hold a valid instruction.
- ifid_instr  out  32  fetched instruction.
- ifid_pc  out  32  address of ifid_instr.
- fetch_err  out  1  sticky timeout error.

Behaviour:
- States: IDLE, FETCH, HOLD, ERR.
- Reset (rst=0 at a clock edge):
  - state=IDLE; pc=RESET_PC.
  - ifid_valid=0, ifid_instr=0, ifid_pc=0, fetch_err=0.
  - wait counter (4 bits) = 0.
  - Reset overrides everything, including a fetch in progress.
- IDLE:
  - imem_read=0.
  - Goes to FETCH on the next edge unconditionally, unless redirect_valid is high (apply redirect, then go to FETCH).
- Priority at each edge in IDLE, FETCH and HOLD: redirect > stall > normal fetch.
- Redirect:
  - pc <= {redirect_pc[31:2],2'b00}; misaligned low bits are dropped.
  - ifid_valid <= 0 (flush); wait counter <= 0; next state FETCH.
  - Any imem_ready/imem_rdata in the redirect cycle is discarded.
  - imem_read is 0 in the redirect cycle.
- FETCH with ifid_valid=1 and stall_in=1:
  - imem_read=0; IF/ID registers unchanged; next state HOLD.
- FETCH otherwise (slot free, or old instruction consumed because stall_in=0):
  - imem_read=1.
  - If imem_ready=1: ifid_instr<=imem_rdata; ifid_pc<=pc; ifid_valid<=1; pc<=pc+4; counter<=0.
  - If imem_ready=0: ifid_valid<=0 and counter<=counter+1.
  - If imem_ready=0 and counter==TIMEOUT-1: next state ERR instead.
- HOLD:
  - imem_read=0; IF/ID registers and pc unchanged.
  - When stall_in=0, go to FETCH on the next edge; that edge does not consume the slot.
  - The held instruction is consumed in the first FETCH cycle with stall_in=0.
- ERR:
  - imem_read=0; ifid_valid<=0; fetch_err=1.
  - Only reset exits; redirect and stall are ignored.
- Latency:
  - With zero-wait memory, one instruction per cycle.
  - First ifid_valid is 2 edges after rst releases: IDLE edge, then FETCH edge.
- Arithmetic:
  - pc+4 wraps modulo 2^32; 32'hFFFF_FFFC -> 32'h0000_0000.
- imem_addr = pc at all times, including during reset.
- Simultaneous redirect_valid and stall_in: redirect wins; IF/ID is flushed even though decode is stalled.

Test Plan:
- Reset, then stream: rst low 2 cycles, release, imem_ready=1 always, rdata=addr^32'hA5A5_0000 → ifid_valid rises on the 2nd edge with ifid_pc=0; then ifid_pc 4, 8, 12 on consecutive cycles with matching instr; imem_read=0 in IDLE.
- Stall: stall_in=1 for 3 cycles while ifid_pc=8 valid → ifid_pc/instr held at 8; imem_read=0; pc stays 12. After release, the next valid instruction is pc=12 with no skipped or duplicated address.
- Redirect: redirect_valid with redirect_pc=32'h0000_0103 while imem_ready=1 → that data is dropped; ifid_valid=0 next cycle; imem_addr=32'h0000_0100; next valid ifid_pc=0x100. Repeat with stall_in=1 in the same cycle → identical result.
- Wait states and timeout:
  - imem_ready low for 3 cycles then high → exactly one capture; ifid_valid low during the waits.
  - TIMEOUT=15 with ready held low → ERR after the 15th wait cycle; fetch_err=1 and stays 1 through redirects.
  - Reset clears fetch_err.
- Wrap: redirect to 32'hFFFF_FFFC, ready=1 → ifid_pc FFFF_FFFC then 0000_0000.
- Reset mid-operation: assert rst in HOLD with ifid_valid=1 → next edge all outputs return to reset values; pc=RESET_PC.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_ctrl
// Brief    : Instruction-fetch sequencer: PC, imem handshake, IF/ID slot,
//            stall / redirect handling and sticky memory-timeout error.
// Revision : 1.0
// ============================================================================
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [3:0] c_CNT_LAST = 4'(TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_ifpc;
    logic [3:0]  r_cnt;

    state_t      w_state;
    logic [31:0] w_pc;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_ifpc;
    logic [3:0]  w_cnt;
    logic        w_read;
    logic [31:0] w_redir_pc;
    logic [1:0]  w_unused_bits;

    // Targets are word-aligned; low address bits of a redirect are dropped.
    assign w_redir_pc    = {redirect_pc[31:2], 2'b00};
    assign w_unused_bits = redirect_pc[1:0];

    always_comb begin
        w_state = r_state;
        w_pc    = r_pc;
        w_valid = r_valid;
        w_instr = r_instr;
        w_ifpc  = r_ifpc;
        w_cnt   = r_cnt;
        w_read  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (redirect_valid) begin
                    w_pc    = w_redir_pc;
                    w_valid = 1'b0;
                    w_cnt   = 4'd0;
                end
                w_state = S_FETCH;
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    w_pc    = w_redir_pc;
                    w_valid = 1'b0;
                    w_cnt   = 4'd0;
                    w_state = S_FETCH;
                end else if (r_valid && stall_in) begin
                    w_state = S_HOLD;
                end else begin
                    w_read = 1'b1;
                    if (imem_ready) begin
                        w_instr = imem_rdata;
                        w_ifpc  = r_pc;
                        w_valid = 1'b1;
                        w_pc    = r_pc + 32'd4;
                        w_cnt   = 4'd0;
                    end else begin
                        w_valid = 1'b0;
                        w_cnt   = r_cnt + 4'd1;
                        if (r_cnt == c_CNT_LAST) begin
                            w_state = S_ERR;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    w_pc    = w_redir_pc;
                    w_valid = 1'b0;
                    w_cnt   = 4'd0;
                    w_state = S_FETCH;
                end else if (!stall_in) begin
                    // Leaving HOLD does not consume the held slot.
                    w_state = S_FETCH;
                end
            end
            S_ERR: begin
                w_valid = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_instr <= 32'd0;
            r_ifpc  <= 32'd0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state;
            r_pc    <= w_pc;
            r_valid <= w_valid;
            r_instr <= w_instr;
            r_ifpc  <= w_ifpc;
            r_cnt   <= w_cnt;
        end
    end

    assign imem_read  = w_read;
    assign imem_addr  = r_pc;
    assign ifid_valid = r_valid;
    assign ifid_instr = r_instr;
    assign ifid_pc    = r_ifpc;
    assign fetch_err  = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_ctrl
// Brief    : Self-checking bench for if_fetch_ctrl: per-cycle vector table,
//            fetched-instruction scoreboard and a timeout/error sequence.
// Revision : 1.0
// ============================================================================
module tb_if_fetch_ctrl;

    localparam logic [31:0] c_XOR = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        fetch_err;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ c_XOR;

    if_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (15)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .imem_read      (imem_read),
        .imem_addr      (imem_addr),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .fetch_err      (fetch_err)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_err;
    } vec_t;

    localparam int c_NVEC = 24;
    vec_t        tbl [c_NVEC];
    logic [31:0] exp_q [$];
    int          checks   = 0;
    int          failures = 0;
    int          cur_row  = -1;
    logic        prev_v   = 1'b0;
    logic [31:0] prev_pc  = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h expected=%h", name, cur_row, act, exp);
        end
    endtask

    // A new instruction appears when valid rises or the presented PC changes.
    task automatic sb_sample();
        logic [31:0] e;
        if (ifid_valid === 1'b1 && (!prev_v || ifid_pc !== prev_pc)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra row=%0d actual=%h expected=none", cur_row, ifid_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", ifid_pc, e);
                chk("sb_instr", ifid_instr, e ^ c_XOR);
            end
        end
        prev_v  = ifid_valid;
        prev_pc = ifid_pc;
    endtask

    task automatic drive(input logic r, input logic s, input logic rv,
                         input logic [31:0] rp, input logic rd);
        rst            = r;
        stall_in       = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        imem_ready     = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          rst   stl   rdr   rpc           rdy   read  addr          vld   ifid_pc       err
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h103,      1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_000C, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_000C, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h103,      1'b1, 1'b0, 32'h0000_0104, 1'b1, 32'h0000_0100, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0100, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0104, 1'b0, 32'h0000_0100, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0104, 1'b0, 32'h0000_0100, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0104, 1'b0, 32'h0000_0100, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0000_0108, 1'b1, 32'h0000_0104, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0104, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 1'b0};
        tbl[21] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0};
        tbl[22] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0};
        tbl[23] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};

        // Every instruction decode should see, in order, for the table run.
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        exp_q.push_back(32'h0000_0008);
        exp_q.push_back(32'h0000_000C);
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0104);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);

        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();

        for (int i = 0; i < c_NVEC; i++) begin
            cur_row = i;
            drive(tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
            @(negedge clk);
            chk("imem_read",  {31'd0, imem_read},  {31'd0, tbl[i].e_read});
            chk("imem_addr",  imem_addr,           tbl[i].e_addr);
            chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, tbl[i].e_valid});
            chk("ifid_pc",    ifid_pc,             tbl[i].e_pc);
            chk("fetch_err",  {31'd0, fetch_err},  {31'd0, tbl[i].e_err});
            if (!tbl[i].rst) begin
                chk("ifid_instr_rst", ifid_instr, (i == 23) ? 32'd0 : ifid_instr ^ 32'd0);
            end
            sb_sample();
            next_cycle();
        end
        cur_row = 100;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        // Timeout: out of reset (pc=0), memory never ready.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();
        for (int w = 0; w < 15; w++) begin
            cur_row = 200 + w;
            @(negedge clk);
            chk("to_read", {31'd0, imem_read}, 32'd1);
            chk("to_err",  {31'd0, fetch_err}, 32'd0);
            next_cycle();
        end
        cur_row = 300;
        @(negedge clk);
        chk("err_set",   {31'd0, fetch_err},  32'd1);
        chk("err_read",  {31'd0, imem_read},  32'd0);
        chk("err_valid", {31'd0, ifid_valid}, 32'd0);

        for (int k = 0; k < 3; k++) begin
            cur_row = 301 + k;
            drive(1'b1, k[0], 1'b1, 32'h0000_0200, 1'b1);
            next_cycle();
            @(negedge clk);
            chk("err_sticky", {31'd0, fetch_err},  32'd1);
            chk("err_addr",   imem_addr,           32'd0);
            chk("err_vld",    {31'd0, ifid_valid}, 32'd0);
        end

        cur_row = 400;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("rst_err_clr", {31'd0, fetch_err}, 32'd0);
        chk("rst_addr",    imem_addr,          32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
